thermostat_scheduler: RTL and testbench

//  Control core between the I2C temperature front end and the HVAC relay outputs.

---
 rtl/thermostat_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_thermostat_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/thermostat_scheduler.sv
// Thermostat control core: periodic temperature sampling with a 4-sample moving
// average, hysteretic setpoint compare and a heat/cool FSM with min-run/min-off timing.
module thermostat_scheduler #(
  parameter int SAMPLE_PERIOD = 560,
  parameter int MIN_RUN       = 2000,
  parameter int MIN_OFF       = 2000,
  parameter int HYST          = 1,
  parameter int SP_MIN        = 50,
  parameter int SP_MAX        = 90,
  parameter int SP_DEFAULT    = 72
) (
  input  logic       clk_200kHz,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] temp_f,
  input  logic       sp_up,
  input  logic       sp_down,
  input  logic [1:0] mode,
  output logic [7:0] setpoint,
  output logic [7:0] temp_avg,
  output logic       avg_valid,
  output logic       heat_on,
  output logic       cool_on,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_HEAT    = 2'b01,
    ST_COOL    = 2'b10,
    ST_LOCKOUT = 2'b11
  } state_t;

  localparam int CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CW-1:0] CAP_LAST = CW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [15:0]   RUN_LAST = 16'(MIN_RUN - 1);
  localparam logic [15:0]   OFF_LAST = 16'(MIN_OFF - 1);
  localparam logic [7:0]    SP_LO    = 8'(SP_MIN);
  localparam logic [7:0]    SP_HI    = 8'(SP_MAX);
  localparam logic [7:0]    SP_RST   = 8'(SP_DEFAULT);
  localparam logic [8:0]    HYST9    = 9'(HYST);

  logic [CW-1:0] sample_cnt_r;
  logic [7:0]    hist0_r;
  logic [7:0]    hist1_r;
  logic [7:0]    hist2_r;
  logic [7:0]    hist3_r;
  logic [2:0]    fill_r;
  logic [9:0]    sum_s;
  logic [7:0]    temp_avg_r;
  logic          avg_valid_r;
  logic [7:0]    setpoint_r;
  state_t        state_r;
  logic [15:0]   timer_r;
  logic          heat_on_r;
  logic          cool_on_r;

  logic [8:0]    avg9_s;
  logic [8:0]    sp_lo_s;
  logic [8:0]    sp_hi_s;
  logic          cold_s;
  logic          warm_s;
  logic          heat_ok_s;
  logic          cool_ok_s;
  logic          heat_done_s;
  logic          cool_done_s;
  logic          run_done_s;
  logic          off_done_s;
  logic [15:0]   timer_inc_s;

  // Capture cadence, history shift register and fill tracking
  always_ff @(posedge clk_200kHz or negedge reset) begin
    if (!reset) begin
      sample_cnt_r <= '0;
      hist0_r      <= 8'd0;
      hist1_r      <= 8'd0;
      hist2_r      <= 8'd0;
      hist3_r      <= 8'd0;
      fill_r       <= 3'd0;
    end else begin
      if (sample_cnt_r == CAP_LAST) begin
        sample_cnt_r <= '0;
        hist0_r      <= temp_f;
        hist1_r      <= hist0_r;
        hist2_r      <= hist1_r;
        hist3_r      <= hist2_r;
        if (fill_r != 3'd4) begin
          fill_r <= fill_r + 3'd1;
        end else begin
          fill_r <= fill_r;
        end
      end else begin
        sample_cnt_r <= sample_cnt_r + CNT_ONE;
      end
    end
  end

  // Ten-bit running sum of the history window
  always_comb begin
    sum_s = {2'b00, hist0_r} + {2'b00, hist1_r} + {2'b00, hist2_r} + {2'b00, hist3_r};
  end

  // Average and its valid flag trail the history by one cycle, so they rise together
  always_ff @(posedge clk_200kHz or negedge reset) begin
    if (!reset) begin
      temp_avg_r  <= 8'd0;
      avg_valid_r <= 1'b0;
    end else begin
      temp_avg_r  <= 8'(sum_s >> 2);
      avg_valid_r <= (fill_r == 3'd4);
    end
  end

  // Setpoint adjust with saturation; simultaneous up/down cancels
  always_ff @(posedge clk_200kHz or negedge reset) begin
    if (!reset) begin
      setpoint_r <= SP_RST;
    end else begin
      if (sp_up && !sp_down && (setpoint_r < SP_HI)) begin
        setpoint_r <= setpoint_r + 8'd1;
      end else if (sp_down && !sp_up && (setpoint_r > SP_LO)) begin
        setpoint_r <= setpoint_r - 8'd1;
      end else begin
        setpoint_r <= setpoint_r;
      end
    end
  end

  // Hysteresis compares in 9 bits so setpoint +/- HYST cannot wrap
  always_comb begin
    avg9_s      = {1'b0, temp_avg_r};
    sp_lo_s     = {1'b0, setpoint_r} - HYST9;
    sp_hi_s     = {1'b0, setpoint_r} + HYST9;
    cold_s      = avg9_s < sp_lo_s;
    warm_s      = avg9_s > sp_hi_s;
    heat_done_s = avg9_s >= sp_hi_s;
    cool_done_s = avg9_s <= sp_lo_s;
    heat_ok_s   = mode[0];
    cool_ok_s   = mode[1];
    run_done_s  = timer_r >= RUN_LAST;
    off_done_s  = timer_r == OFF_LAST;
    if (timer_r != 16'hFFFF) begin
      timer_inc_s = timer_r + 16'd1;
    end else begin
      timer_inc_s = timer_r;
    end
  end

  // Plant FSM; relay requests are registered alongside the state so they can never overlap
  always_ff @(posedge clk_200kHz or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      timer_r   <= 16'd0;
      heat_on_r <= 1'b0;
      cool_on_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          timer_r <= 16'd0;
          if (enable && avg_valid_r && heat_ok_s && cold_s) begin
            state_r   <= ST_HEAT;
            heat_on_r <= 1'b1;
            cool_on_r <= 1'b0;
          end else if (enable && avg_valid_r && cool_ok_s && warm_s) begin
            state_r   <= ST_COOL;
            heat_on_r <= 1'b0;
            cool_on_r <= 1'b1;
          end else begin
            state_r   <= ST_IDLE;
            heat_on_r <= 1'b0;
            cool_on_r <= 1'b0;
          end
        end
        ST_HEAT: begin
          cool_on_r <= 1'b0;
          if (!enable || (run_done_s && (heat_done_s || !heat_ok_s))) begin
            state_r   <= ST_LOCKOUT;
            timer_r   <= 16'd0;
            heat_on_r <= 1'b0;
          end else begin
            state_r   <= ST_HEAT;
            timer_r   <= timer_inc_s;
            heat_on_r <= 1'b1;
          end
        end
        ST_COOL: begin
          heat_on_r <= 1'b0;
          if (!enable || (run_done_s && (cool_done_s || !cool_ok_s))) begin
            state_r   <= ST_LOCKOUT;
            timer_r   <= 16'd0;
            cool_on_r <= 1'b0;
          end else begin
            state_r   <= ST_COOL;
            timer_r   <= timer_inc_s;
            cool_on_r <= 1'b1;
          end
        end
        ST_LOCKOUT: begin
          heat_on_r <= 1'b0;
          cool_on_r <= 1'b0;
          if (off_done_s) begin
            state_r <= ST_IDLE;
            timer_r <= 16'd0;
          end else begin
            state_r <= ST_LOCKOUT;
            timer_r <= timer_inc_s;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          timer_r   <= 16'd0;
          heat_on_r <= 1'b0;
          cool_on_r <= 1'b0;
        end
      endcase
    end
  end

  assign setpoint  = setpoint_r;
  assign temp_avg  = temp_avg_r;
  assign avg_valid = avg_valid_r;
  assign heat_on   = heat_on_r;
  assign cool_on   = cool_on_r;
  assign fsm_state = state_r;

endmodule

// File: tb/tb_thermostat_scheduler.sv
// Directed bench for thermostat_scheduler with shortened timing parameters
// (SAMPLE_PERIOD=4, MIN_RUN=20, MIN_OFF=10, HYST=1).
module tb_thermostat_scheduler;

  logic       clk_200kHz;
  logic       reset;
  logic       enable;
  logic [7:0] temp_f;
  logic       sp_up;
  logic       sp_down;
  logic [1:0] mode;
  logic [7:0] setpoint;
  logic [7:0] temp_avg;
  logic       avg_valid;
  logic       heat_on;
  logic       cool_on;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_HEAT = 2'b01;
  localparam logic [1:0] S_COOL = 2'b10;
  localparam logic [1:0] S_LOCK = 2'b11;

  thermostat_scheduler #(
    .SAMPLE_PERIOD(4),
    .MIN_RUN(20),
    .MIN_OFF(10),
    .HYST(1)
  ) dut (
    .clk_200kHz(clk_200kHz),
    .reset(reset),
    .enable(enable),
    .temp_f(temp_f),
    .sp_up(sp_up),
    .sp_down(sp_down),
    .mode(mode),
    .setpoint(setpoint),
    .temp_avg(temp_avg),
    .avg_valid(avg_valid),
    .heat_on(heat_on),
    .cool_on(cool_on),
    .fsm_state(fsm_state)
  );

  initial clk_200kHz = 1'b0;
  always #5 clk_200kHz = ~clk_200kHz;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // n rising edges, then settle on the falling edge for sampling/driving
  task automatic step(input int n);
    repeat (n) @(posedge clk_200kHz);
    @(negedge clk_200kHz);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] target, input int budget);
    int n;
    n = 0;
    while (fsm_state !== target && n < budget) begin
      step(1);
      n++;
    end
    check_val(tag, 16'(fsm_state), 16'(target));
  endtask

  task automatic pulse_up(input int n);
    for (int i = 0; i < n; i++) begin
      sp_up = 1'b1;
      step(1);
      sp_up = 1'b0;
      step(1);
    end
  endtask

  task automatic pulse_down(input int n);
    for (int i = 0; i < n; i++) begin
      sp_down = 1'b1;
      step(1);
      sp_down = 1'b0;
      step(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int both;
    logic [1:0] first_exit;
    logic exit_seen;

    reset   = 1'b0;
    enable  = 1'b1;
    temp_f  = 8'd70;
    sp_up   = 1'b0;
    sp_down = 1'b0;
    mode    = 2'b00;

    // 1) reset values and first full average
    step(2);
    check_val("rst_setpoint", 16'(setpoint), 16'd72);
    check_val("rst_temp_avg", 16'(temp_avg), 16'd0);
    check_val("rst_avg_valid", 16'(avg_valid), 16'd0);
    check_val("rst_heat_on", 16'(heat_on), 16'd0);
    check_val("rst_cool_on", 16'(cool_on), 16'd0);
    check_val("rst_state", 16'(fsm_state), 16'(S_IDLE));
    reset = 1'b1;
    step(16);
    check_val("valid_before_4th", 16'(avg_valid), 16'd0);
    step(1);
    check_val("valid_after_4th", 16'(avg_valid), 16'd1);
    check_val("avg_70", 16'(temp_avg), 16'd70);
    check_val("mode_off_idle", 16'(fsm_state), 16'(S_IDLE));

    // 2) heat run: min run, lockout, back to idle
    mode   = 2'b01;
    temp_f = 8'd60;
    wait_state("enter_heat", S_HEAT, 40);
    check_val("heat_on_in_heat", 16'(heat_on), 16'd1);
    check_val("cool_off_in_heat", 16'(cool_on), 16'd0);
    temp_f = 8'd80;
    n = 0;
    while (heat_on === 1'b1 && n < 100) begin
      n++;
      step(1);
    end
    check_val("heat_run_len", 16'(n), 16'd20);
    check_val("heat_to_lockout", 16'(fsm_state), 16'(S_LOCK));
    n = 0;
    while (fsm_state === S_LOCK && n < 100) begin
      n++;
      step(1);
    end
    check_val("lockout_len", 16'(n), 16'd10);
    check_val("lockout_to_idle", 16'(fsm_state), 16'(S_IDLE));

    // 3) auto mode: cool, then through lockout into heat
    mode   = 2'b11;
    temp_f = 8'd90;
    wait_state("enter_cool", S_COOL, 40);
    check_val("cool_on_in_cool", 16'(cool_on), 16'd1);
    check_val("heat_off_in_cool", 16'(heat_on), 16'd0);
    temp_f     = 8'd50;
    both       = 0;
    exit_seen  = 1'b0;
    first_exit = S_COOL;
    n = 0;
    while (fsm_state !== S_HEAT && n < 200) begin
      step(1);
      n++;
      if (heat_on === 1'b1 && cool_on === 1'b1) both++;
      if (!exit_seen && fsm_state !== S_COOL) begin
        exit_seen  = 1'b1;
        first_exit = fsm_state;
      end
    end
    check_val("cool_exit_state", 16'(first_exit), 16'(S_LOCK));
    check_val("never_both_on", 16'(both), 16'd0);
    check_val("reach_heat", 16'(fsm_state), 16'(S_HEAT));
    check_val("heat_on_after_cool", 16'(heat_on), 16'd1);

    // 4) setpoint saturation and cancel
    mode = 2'b00;
    pulse_up(25);
    check_val("sp_sat_max", 16'(setpoint), 16'd90);
    sp_up   = 1'b1;
    sp_down = 1'b1;
    step(1);
    sp_up   = 1'b0;
    sp_down = 1'b0;
    step(1);
    check_val("sp_both_hold", 16'(setpoint), 16'd90);
    pulse_down(1);
    check_val("sp_down_one", 16'(setpoint), 16'd89);
    pulse_down(44);
    check_val("sp_sat_min", 16'(setpoint), 16'd50);
    pulse_up(22);
    check_val("sp_back_72", 16'(setpoint), 16'd72);

    // 5) enable drop mid-heat overrides minimum run
    check_val("idle_before_t5", 16'(fsm_state), 16'(S_IDLE));
    mode = 2'b01;
    wait_state("t5_enter_heat", S_HEAT, 10);
    step(5);
    check_val("t5_heat_at_5", 16'(heat_on), 16'd1);
    enable = 1'b0;
    step(1);
    check_val("t5_heat_dropped", 16'(heat_on), 16'd0);
    check_val("t5_lockout", 16'(fsm_state), 16'(S_LOCK));
    n = 0;
    while (fsm_state === S_LOCK && n < 100) begin
      n++;
      step(1);
    end
    check_val("t5_lockout_len", 16'(n), 16'd10);
    step(10);
    check_val("t5_disabled_idle", 16'(fsm_state), 16'(S_IDLE));

    // 6) asynchronous reset during a cool run
    pulse_up(2);
    check_val("sp_74", 16'(setpoint), 16'd74);
    mode   = 2'b10;
    enable = 1'b1;
    temp_f = 8'd90;
    wait_state("t6_enter_cool", S_COOL, 60);
    check_val("t6_cool_on", 16'(cool_on), 16'd1);
    step(3);
    #2;
    reset = 1'b0;
    #1;
    check_val("t6_async_cool_off", 16'(cool_on), 16'd0);
    check_val("t6_async_idle", 16'(fsm_state), 16'(S_IDLE));
    @(negedge clk_200kHz);
    check_val("t6_sp_default", 16'(setpoint), 16'd72);
    check_val("t6_valid_clear", 16'(avg_valid), 16'd0);
    check_val("t6_avg_clear", 16'(temp_avg), 16'd0);
    reset = 1'b1;
    step(16);
    check_val("t6_refill_not_valid", 16'(avg_valid), 16'd0);
    step(1);
    check_val("t6_refill_valid", 16'(avg_valid), 16'd1);
    check_val("t6_refill_avg", 16'(temp_avg), 16'd90);
    check_val("t6_refill_idle", 16'(fsm_state), 16'(S_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
